// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile write-back path.
package regfile_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  // Register 0 is hard-wired; writes to it are discarded.
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // One pending register write: destination select plus result data.
  typedef struct packed {
    logic [REG_AW-1:0] dsel;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of pending writes; exposes every slot together
// with a validity mask so the top level can match destinations for hazards.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output wb_entry_t                  o_entries [DEPTH],
  output logic [DEPTH-1:0]           o_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  wb_entry_t     r_mem [DEPTH];

  logic w_push_en;
  logic w_pop_en;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;
  assign w_push_en = i_push && !o_full;
  assign w_pop_en  = i_pop && !o_empty;

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately left unreset; o_valid masks stale slots, so
  // clearing the array would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    logic [PW-1:0] w_off;
    // NOTE: every combinational output gets a default first so no latch forms.
    o_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PW'(i) - r_rd_ptr;
      o_valid[i] = (CW'(w_off) < r_count);
    end
  end

endmodule : wb_fifo

// File: rtl/regfile_writeback.sv
// Write-side front end for the regfile: arbitrates ALU/load results into an
// in-order queue, issues one registered write per cycle, flags pending writes.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_dsel,
  input  logic [DW-1:0]              alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_dsel,
  input  logic [DW-1:0]              mem_data,
  input  logic                       wb_hold,
  output logic                       RW,
  output logic [AW-1:0]              Dsel,
  output logic [DW-1:0]              DIN,
  input  logic [AW-1:0]              Asel,
  input  logic [AW-1:0]              Bsel,
  output logic                       a_busy,
  output logic                       b_busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  wb_entry_t        w_push_entry;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_mem_fire;
  logic             w_alu_fire;
  logic             w_push;
  logic             w_pop;

  // Load results win; the ALU waits whenever a load is offered.
  assign mem_ready  = reset && !w_full;
  assign alu_ready  = reset && !w_full && !mem_valid;
  assign w_mem_fire = mem_valid && mem_ready;
  assign w_alu_fire = alu_valid && alu_ready;

  // Accepted writes to register 0 complete the handshake but never enqueue.
  assign w_push_entry = w_mem_fire ? '{dsel: mem_dsel, data: mem_data}
                                   : '{dsel: alu_dsel, data: alu_data};
  assign w_push = (w_mem_fire && (mem_dsel != REG_ZERO)) ||
                  (w_alu_fire && (alu_dsel != REG_ZERO));
  assign w_pop  = !wb_hold && !w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clock),
    .rst_n        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (count),
    .o_entries    (w_entries),
    .o_valid      (w_valid)
  );

  // Registered regfile write port: one-cycle RW pulse per popped entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      RW   <= 1'b0;
      Dsel <= '0;
      DIN  <= '0;
    end else if (w_pop) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      RW   <= 1'b1;
      Dsel <= w_head.dsel;
      DIN  <= w_head.data;
    end else begin
      RW   <= 1'b0;
    end
  end

  // Hazard flags: any queued write or the in-flight write targeting a select.
  always_comb begin
    logic w_hit_a;
    logic w_hit_b;
    w_hit_a = RW && (Dsel == Asel);
    w_hit_b = RW && (Dsel == Bsel);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].dsel == Asel)) w_hit_a = 1'b1;
      if (w_valid[i] && (w_entries[i].dsel == Bsel)) w_hit_b = 1'b1;
    end
    a_busy = (Asel != REG_ZERO) && w_hit_a;
    b_busy = (Bsel != REG_ZERO) && w_hit_b;
  end

endmodule : regfile_writeback

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback (DEPTH=4).
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clock;
  logic          reset;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_dsel;
  logic [DW-1:0] alu_data;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_dsel;
  logic [DW-1:0] mem_data;
  logic          wb_hold;
  logic          RW;
  logic [AW-1:0] Dsel;
  logic [DW-1:0] DIN;
  logic [AW-1:0] Asel, Bsel;
  logic          a_busy, b_busy;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  regfile_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dsel  (alu_dsel),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dsel  (mem_dsel),
    .mem_data  (mem_data),
    .wb_hold   (wb_hold),
    .RW        (RW),
    .Dsel      (Dsel),
    .DIN       (DIN),
    .Asel      (Asel),
    .Bsel      (Bsel),
    .a_busy    (a_busy),
    .b_busy    (b_busy),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    alu_valid = 1'b1; alu_dsel = 5'd9;  alu_data = 32'h99;
    mem_valid = 1'b1; mem_dsel = 5'd10; mem_data = 32'hAA;
    wb_hold   = 1'b0;
    Asel      = 5'd0; Bsel = 5'd0;

    // 1. Reset with both offers high.
    repeat (3) tick();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_rw",        RW,        0);
    check("rst_dsel",      Dsel,      0);
    check("rst_din",       DIN,       0);
    check("rst_count",     count,     0);
    reset = 1'b1;
    #1;
    check("rel_mem_ready", mem_ready, 1);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();
    check("idle_count", count, 0);

    // 2. Single ALU write r5 = DEADBEEF.
    alu_valid = 1'b1; alu_dsel = 5'd5; alu_data = 32'hDEADBEEF;
    Asel = 5'd5;
    #1;
    check("s_alu_ready", alu_ready, 1);
    check("s_busy_pre",  a_busy,    0);
    tick();                               // edge N: accepted
    alu_valid = 1'b0;
    #1;
    check("s_count_n",  count,  1);
    check("s_busy_n",   a_busy, 1);
    check("s_rw_n",     RW,     0);
    tick();                               // edge N+1: popped
    check("s_rw_n1",    RW,     1);
    check("s_dsel_n1",  Dsel,   5);
    check("s_din_n1",   DIN,    32'hDEADBEEF);
    check("s_busy_n1",  a_busy, 1);
    check("s_count_n1", count,  0);
    tick();                               // edge N+2: committed
    check("s_rw_n2",    RW,     0);
    check("s_busy_n2",  a_busy, 0);
    check("s_dsel_hold", Dsel,  5);
    check("s_din_hold",  DIN,   32'hDEADBEEF);

    // 3. Simultaneous offers: mem r4 first, then ALU r3.
    mem_valid = 1'b1; mem_dsel = 5'd4; mem_data = 32'h11;
    alu_valid = 1'b1; alu_dsel = 5'd3; alu_data = 32'h22;
    Bsel = 5'd3;
    #1;
    check("c_alu_ready0", alu_ready, 0);
    check("c_mem_ready0", mem_ready, 1);
    check("c_bbusy_pre",  b_busy,    0);
    tick();                               // mem accepted
    mem_valid = 1'b0;
    #1;
    check("c_alu_ready1", alu_ready, 1);
    check("c_count1",     count,     1);
    tick();                               // alu accepted, r4 issued
    alu_valid = 1'b0;
    check("c_rw1",   RW,     1);
    check("c_dsel1", Dsel,   4);
    check("c_din1",  DIN,    32'h11);
    check("c_bbusy", b_busy, 1);
    tick();
    check("c_rw2",   RW,   1);
    check("c_dsel2", Dsel, 3);
    check("c_din2",  DIN,  32'h22);
    tick();
    check("c_rw3",   RW,     0);
    check("c_bbusy_post", b_busy, 0);

    // 4. Hold and fill with r1..r4, r5 held until drain starts.
    wb_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_dsel = AW'(k); alu_data = 32'(k * 256);
      tick();
      check("h_rw_held", RW, 0);
    end
    alu_dsel = 5'd5; alu_data = 32'h500;
    #1;
    check("h_count_full",  count,     4);
    check("h_alu_ready",   alu_ready, 0);
    check("h_mem_ready",   mem_ready, 0);
    tick();
    check("h_count_stay",  count,     4);
    wb_hold = 1'b0;
    tick();                               // pop r1, r5 refused (full pre-edge)
    check("h_rw1",   RW,        1);
    check("h_dsel1", Dsel,      1);
    check("h_din1",  DIN,       32'h100);
    check("h_cnt1",  count,     3);
    check("h_ready", alu_ready, 1);
    tick();                               // pop r2, r5 accepted
    alu_valid = 1'b0;
    check("h_dsel2", Dsel,  2);
    check("h_cnt2",  count, 3);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check("h_rw_k",   RW,   1);
      check("h_dsel_k", Dsel, AW'(k));
      check("h_din_k",  DIN,  32'(k * 256));
    end
    tick();
    check("h_rw_end",  RW,    0);
    check("h_cnt_end", count, 0);

    // 5. Register 0 write is accepted and dropped.
    alu_valid = 1'b1; alu_dsel = 5'd0; alu_data = 32'hFFFF;
    Asel = 5'd0;
    #1;
    check("z_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    #1;
    check("z_count", count,  0);
    check("z_busy",  a_busy, 0);
    tick();
    check("z_rw1", RW, 0);
    tick();
    check("z_rw2", RW, 0);

    // 6. Reset mid-operation with writes pending.
    wb_hold = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      alu_valid = 1'b1; alu_dsel = AW'(k); alu_data = 32'(k);
      tick();
    end
    alu_valid = 1'b0;
    wb_hold   = 1'b0;
    Asel      = 5'd7;
    tick();                               // r6 issued, 3 left
    check("m_rw_pre",   RW,     1);
    check("m_cnt_pre",  count,  3);
    check("m_busy_pre", a_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("m_rw_async",   RW,     0);
    check("m_cnt_async",  count,  0);
    check("m_dsel_async", Dsel,   0);
    check("m_din_async",  DIN,    0);
    check("m_busy_async", a_busy, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("m_rw_after",  RW,    0);
      check("m_cnt_after", count, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_writeback
